// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit.
//  - state_t      : FSM encoding (IDLE / REQ / DONE)
//  - LANE_*       : byte-lane indices within a big-endian 32-bit word
//  - be_from_lane : byte-enable pattern for a given lane and access size
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Big-endian: the lowest byte address holds the most significant byte.
  localparam logic [1:0] LANE_31_24 = 2'd0;
  localparam logic [1:0] LANE_23_16 = 2'd1;
  localparam logic [1:0] LANE_15_8  = 2'd2;
  localparam logic [1:0] LANE_7_0   = 2'd3;

  function automatic logic [3:0] be_from_lane(input logic [1:0] lane, input logic byte_op);
    logic [3:0] be;
    if (!byte_op) begin
      be = 4'b1111;
    end else begin
      case (lane)
        LANE_31_24: be = 4'b1000;
        LANE_23_16: be = 4'b0100;
        LANE_15_8:  be = 4'b0010;
        default:    be = 4'b0001;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_align.sv
// byte_lane_align: combinational lane steering for the access unit.
// Ports:
//  lane      in  2   byte address bits [1:0]
//  byte_op   in  1   1 = byte access, 0 = word access
//  wdata     in  32  raw store data (byte stores use [7:0])
//  rdata     in  32  raw memory read data
//  be        out 4   byte enables, be[3] -> bits [31:24]
//  wdata_out out 32  store data replicated across all lanes for byte stores
//  rdata_out out 32  load result, zero-extended selected byte for byte loads
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic        byte_op,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [7:0] sel_byte;

  always_comb begin
    be        = be_from_lane(lane, byte_op);
    wdata_out = byte_op ? {4{wdata[7:0]}} : wdata;
    case (lane)
      LANE_31_24: sel_byte = rdata[31:24];
      LANE_23_16: sel_byte = rdata[23:16];
      LANE_15_8:  sel_byte = rdata[15:8];
      default:    sel_byte = rdata[7:0];
    endcase
    rdata_out = byte_op ? {24'b0, sel_byte} : rdata;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage responder that turns load/store requests into a
// req/ack data-memory transaction and stalls the pipeline until it completes.
// Ports:
//  clk, rst                  clock, synchronous active-high reset
//  MEM_ReadfromMem/WritetoMem load / store request from the EX/MEM latch
//  MEM_ByteOp, MEM_Addr, MEM_WData  access size, byte address, store data
//  stall                     hold IF..MEM this cycle
//  load_data, load_valid     load result and its 1-cycle valid pulse
//  acc_err                   1-cycle pulse for misaligned/illegal/timed-out access
//  dmem_req/we/addr/be/wdata memory request bundle
//  dmem_ack, dmem_rdata      memory completion and read data
// Handshake: dmem_req rises on entry to REQ and every dmem_* output holds
// steady until the cycle in which dmem_ack=1 is seen (transfer completes on
// that rising edge) or the timeout expires; dmem_ack is ignored outside REQ.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_ReadfromMem,
  input  logic              MEM_WritetoMem,
  input  logic              MEM_ByteOp,
  input  logic [ADDR_W-1:0] MEM_Addr,
  input  logic [31:0]       MEM_WData,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              acc_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-3:0] word_q;
  logic [1:0]        lane_q;
  logic              byte_q, we_q, ld_q, err_q;
  logic [31:0]       wdata_q, load_q;

  logic        req_seen, bad_req, timeout;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign req_seen = MEM_ReadfromMem | MEM_WritetoMem;
  // Illegal: both directions at once, or a word access that is not word aligned.
  assign bad_req  = (MEM_ReadfromMem & MEM_WritetoMem) |
                    (!MEM_ByteOp && (MEM_Addr[1:0] != 2'b00));
  assign timeout  = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Aligner works from captured values so dmem_* stay stable through REQ.
  byte_lane_align u_align (
    .lane      (lane_q),
    .byte_op   (byte_q),
    .wdata     (wdata_q),
    .rdata     (dmem_rdata),
    .be        (al_be),
    .wdata_out (al_wdata),
    .rdata_out (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      byte_q  <= 1'b0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req_seen) begin
            word_q  <= MEM_Addr[ADDR_W-1:2];
            lane_q  <= MEM_Addr[1:0];
            byte_q  <= MEM_ByteOp;
            wdata_q <= MEM_WData;
            we_q    <= MEM_WritetoMem & ~MEM_ReadfromMem;
            ld_q    <= MEM_ReadfromMem & ~MEM_WritetoMem;
            err_q   <= bad_req;
            load_q  <= '0;
          end
        end
        ST_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem_ack) begin
            if (ld_q) load_q <= al_rdata;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    stall      = 1'b0;
    dmem_req   = 1'b0;
    load_valid = 1'b0;
    acc_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_seen) begin
          stall   = 1'b1;
          state_n = bad_req ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ack || timeout) state_n = ST_DONE;
      end
      ST_DONE: begin
        // The request still on the inputs is the one just finished; the
        // pipeline advances on this edge, so it is not re-accepted.
        load_valid = ld_q & ~err_q;
        acc_err    = err_q;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? {word_q, 2'b00} : '0;
  assign dmem_be    = dmem_req ? al_be : 4'b0000;
  assign dmem_wdata = dmem_req ? al_wdata : 32'h0;
  assign load_data  = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: each task drives one scenario and
// checks outputs #1 after the rising edge against hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, bop;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, acc_err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .MEM_ReadfromMem(rd), .MEM_WritetoMem(wr), .MEM_ByteOp(bop),
    .MEM_Addr(addr), .MEM_WData(wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .acc_err(acc_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic b,
                       input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; bop = b; addr = a; wdata = d; #1;
  endtask

  task automatic idle_inputs();
    rd = 0; wr = 0; bop = 0; addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0; #1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst = 1; idle_inputs();
    tick(); tick();
    vecs++;
    if ({stall, load_valid, acc_err, dmem_req, dmem_we} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl got %b want 00000", {stall, load_valid, acc_err, dmem_req, dmem_we});
    end
    vecs++;
    if ({load_data, dmem_addr, dmem_be, dmem_wdata} !== 100'b0) begin
      errs++; $display("FAIL reset_data got ld=%h a=%h be=%b wd=%h want zeros", load_data, dmem_addr, dmem_be, dmem_wdata);
    end
    rst = 0; tick();
  endtask

  task automatic test_lw();
    drive(1, 0, 0, 32'h100, 32'h0);
    vecs++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      errs++; $display("FAIL lw_capture got stall=%b req=%b want 1 0", stall, dmem_req);
    end
    tick();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
    vecs++;
    if ({stall, dmem_req, dmem_we, dmem_be} !== 7'b1101111 || dmem_addr !== 32'h100) begin
      errs++; $display("FAIL lw_req got stall=%b req=%b we=%b be=%b a=%h", stall, dmem_req, dmem_we, dmem_be, dmem_addr);
    end
    tick();
    dmem_ack = 0; dmem_rdata = 0; #1;
    vecs++;
    if (stall !== 1'b0 || load_valid !== 1'b1 || acc_err !== 1'b0 || load_data !== 32'hDEADBEEF) begin
      errs++; $display("FAIL lw_done got stall=%b lv=%b err=%b ld=%h want 0 1 0 deadbeef", stall, load_valid, acc_err, load_data);
    end
    tick();
    idle_inputs();
    vecs++;
    if (stall !== 1'b0 || load_valid !== 1'b0 || dmem_req !== 1'b0) begin
      errs++; $display("FAIL lw_after got stall=%b lv=%b req=%b want 0 0 0", stall, load_valid, dmem_req);
    end
  endtask

  task automatic test_lbu();
    drive(1, 0, 1, 32'h102, 32'h0);
    tick();
    dmem_ack = 1; dmem_rdata = 32'h11223344; #1;
    vecs++;
    if (dmem_addr !== 32'h100 || dmem_be !== 4'b0010 || dmem_we !== 1'b0) begin
      errs++; $display("FAIL lbu_req got a=%h be=%b we=%b want 100 0010 0", dmem_addr, dmem_be, dmem_we);
    end
    tick();
    dmem_ack = 0; #1;
    vecs++;
    if (load_valid !== 1'b1 || load_data !== 32'h00000033) begin
      errs++; $display("FAIL lbu_done got lv=%b ld=%h want 1 00000033", load_valid, load_data);
    end
    tick(); idle_inputs();
  endtask

  task automatic test_sb();
    drive(0, 1, 1, 32'h203, 32'h000000AB);
    tick();
    vecs++;
    if (dmem_we !== 1'b1 || dmem_be !== 4'b0001 || dmem_wdata !== 32'hABABABAB || dmem_addr !== 32'h200) begin
      errs++; $display("FAIL sb_req got we=%b be=%b wd=%h a=%h want 1 0001 abababab 200", dmem_we, dmem_be, dmem_wdata, dmem_addr);
    end
    dmem_ack = 1; #1;
    tick();
    dmem_ack = 0; #1;
    vecs++;
    if (load_valid !== 1'b0 || acc_err !== 1'b0 || stall !== 1'b0) begin
      errs++; $display("FAIL sb_done got lv=%b err=%b stall=%b want 0 0 0", load_valid, acc_err, stall);
    end
    tick(); idle_inputs();
  endtask

  task automatic test_errors();
    // misaligned word load, then read+write together
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive(1, 0, 0, 32'h101, 32'h0);
      else        drive(1, 1, 0, 32'h100, 32'h0);
      vecs++;
      if (stall !== 1'b1 || dmem_req !== 1'b0) begin
        errs++; $display("FAIL err%0d_capture got stall=%b req=%b want 1 0", k, stall, dmem_req);
      end
      tick();
      vecs++;
      if (acc_err !== 1'b1 || load_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
        errs++; $display("FAIL err%0d_done got err=%b lv=%b req=%b stall=%b ld=%h", k, acc_err, load_valid, dmem_req, stall, load_data);
      end
      tick(); idle_inputs();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    drive(0, 1, 0, 32'h300, 32'h12345678);
    tick();
    while (dmem_req === 1'b1 && n < 40) begin
      n++; tick();
    end
    vecs++;
    if (n != 16) begin
      errs++; $display("FAIL timeout_len got %0d req cycles want 16", n);
    end
    vecs++;
    if (acc_err !== 1'b1 || stall !== 1'b0 || load_valid !== 1'b0) begin
      errs++; $display("FAIL timeout_done got err=%b stall=%b lv=%b want 1 0 0", acc_err, stall, load_valid);
    end
    tick(); idle_inputs();
  endtask

  task automatic test_reset_mid_req();
    drive(1, 0, 0, 32'h400, 32'h0);
    tick(); tick(); tick();
    vecs++;
    if (dmem_req !== 1'b1) begin
      errs++; $display("FAIL rstmid_req3 got req=%b want 1", dmem_req);
    end
    rst = 1; idle_inputs();
    tick();
    rst = 0; #1;
    vecs++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || load_valid !== 1'b0 || acc_err !== 1'b0) begin
      errs++; $display("FAIL rstmid_after got req=%b stall=%b lv=%b err=%b want 0", dmem_req, stall, load_valid, acc_err);
    end
    tick();
    vecs++;
    if (load_valid !== 1'b0 || acc_err !== 1'b0) begin
      errs++; $display("FAIL rstmid_nopulse got lv=%b err=%b want 0 0", load_valid, acc_err);
    end
  endtask

  task automatic test_back_to_back();
    int busy = 0;
    drive(1, 0, 0, 32'h500, 32'h0);
    tick();
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D; #1;
    tick();
    dmem_ack = 0; #1;
    vecs++;
    if (load_valid !== 1'b1 || load_data !== 32'hCAFEF00D) begin
      errs++; $display("FAIL b2b_lw got lv=%b ld=%h want 1 cafef00d", load_valid, load_data);
    end
    tick();
    drive(0, 1, 0, 32'h504, 32'h0BADF00D);
    vecs++;
    if (stall !== 1'b1) begin
      errs++; $display("FAIL b2b_sw_capture got stall=%b want 1", stall);
    end
    tick();
    vecs++;
    if (dmem_we !== 1'b1 || dmem_addr !== 32'h504 || dmem_be !== 4'b1111 || dmem_wdata !== 32'h0BADF00D) begin
      errs++; $display("FAIL b2b_sw_req got we=%b a=%h be=%b wd=%h", dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    dmem_ack = 1; #1;
    tick();
    dmem_ack = 0; #1;
    vecs++;
    if (load_valid !== 1'b0 || acc_err !== 1'b0 || stall !== 1'b0) begin
      errs++; $display("FAIL b2b_sw_done got lv=%b err=%b stall=%b want 0 0 0", load_valid, acc_err, stall);
    end
    tick(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (dmem_req !== 1'b0 || load_valid !== 1'b0 || acc_err !== 1'b0) busy++;
      tick();
    end
    vecs++;
    if (busy != 0) begin
      errs++; $display("FAIL b2b_quiet got %0d active cycles want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lbu();
    test_sb();
    test_errors();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
